// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// The master drives the request and operands; the slave returns status and result.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;

    modport master (
        output start, a, b,
        input  ready, busy, done, diff, borrow_out
    );

    modport slave (
        input  start, a, b,
        output ready, busy, done, diff, borrow_out
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial a - b: one full-subtractor cell reused LSB first over WIDTH cycles.
// Status outputs decode straight from state; diff/borrow_out are registers.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_subtractor_if.slave   bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_diff;
    logic             r_br;
    logic             r_borrow_out;
    logic [CW-1:0]    r_cnt;

    logic             w_accept;
    logic             w_last;
    logic             w_d;
    logic             w_br_next;
    logic             w_ready;
    logic             w_busy;
    logic             w_done;

    assign w_last    = (r_cnt == LAST);
    assign w_d       = r_a[0] ^ r_b[0] ^ r_br;
    assign w_br_next = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_ready      = 1'b0;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                if (bus.start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                w_busy = 1'b1;
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_done       = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Result bits enter at the MSB so after WIDTH shifts bit 0 lands at diff[0].
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a          <= '0;
            r_b          <= '0;
            r_diff       <= '0;
            r_br         <= 1'b0;
            r_borrow_out <= 1'b0;
            r_cnt        <= '0;
        end else if (w_accept) begin
            r_a          <= bus.a;
            r_b          <= bus.b;
            r_diff       <= '0;
            r_br         <= 1'b0;
            r_borrow_out <= 1'b0;
            r_cnt        <= '0;
        end else if (r_state == S_RUN) begin
            r_a    <= r_a >> 1;
            r_b    <= r_b >> 1;
            r_diff <= (r_diff >> 1) | (WIDTH'(w_d) << (WIDTH - 1));
            r_br   <= w_br_next;
            r_cnt  <= r_cnt + CW'(1);
            if (w_last) begin
                r_borrow_out <= w_br_next;
            end
        end
    end

    assign bus.ready      = w_ready;
    assign bus.busy       = w_busy;
    assign bus.done       = w_done;
    assign bus.diff       = r_diff;
    assign bus.borrow_out = r_borrow_out;
endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: three lanes (WIDTH 1, 8, 32) on one clock, directed
// cases on the 8-bit lane, then a parallel random sweep against a - b arithmetic.
module tb_serial_subtractor;
    localparam int NOPS = 1000;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic        drv_start [3];
    logic [31:0] drv_a     [3];
    logic [31:0] drv_b     [3];
    logic        mon_ready [3];
    logic        mon_busy  [3];
    logic        mon_done  [3];
    logic [31:0] mon_diff  [3];
    logic        mon_borrow[3];

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_lane
            localparam int W = (gi == 0) ? 1 : (gi == 1) ? 8 : 32;
            serial_subtractor_if #(.WIDTH(W)) u_if ();
            serial_subtractor #(.WIDTH(W)) u_dut (
                .clk (clk),
                .rst (rst),
                .bus (u_if)
            );
            assign u_if.start      = drv_start[gi];
            assign u_if.a          = drv_a[gi][W-1:0];
            assign u_if.b          = drv_b[gi][W-1:0];
            assign mon_ready[gi]   = u_if.ready;
            assign mon_busy[gi]    = u_if.busy;
            assign mon_done[gi]    = u_if.done;
            assign mon_diff[gi]    = 32'(u_if.diff);
            assign mon_borrow[gi]  = u_if.borrow_out;
        end
    endgenerate

    function automatic int lane_w(input int ln);
        return (ln == 0) ? 1 : (ln == 1) ? 8 : 32;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One operation on a lane, entered and left at a falling edge with the lane idle.
    task automatic run_op(input int ln, input logic [31:0] a_in, input logic [31:0] b_in,
                          input bit pulse);
        int          w;
        int          lat;
        logic [63:0] mask;
        logic [63:0] full;
        logic [31:0] a;
        logic [31:0] b;
        w    = lane_w(ln);
        mask = (64'd1 << w) - 64'd1;
        a    = a_in & mask[31:0];
        b    = b_in & mask[31:0];
        full = ({32'd0, a} - {32'd0, b}) & ((mask << 1) | 64'd1);
        check("ready_idle", 64'(mon_ready[ln]), 64'd1);
        drv_start[ln] = 1'b1;
        drv_a[ln]     = a;
        drv_b[ln]     = b;
        @(posedge clk);
        @(negedge clk);
        drv_start[ln] = 1'b0;
        drv_a[ln]     = $urandom;
        drv_b[ln]     = $urandom;
        check("busy_run", 64'(mon_busy[ln]), 64'd1);
        lat = 0;
        while (!mon_done[ln] && lat < w + 4) begin
            if (pulse && lat == 2) begin
                drv_start[ln] = 1'b1;
                drv_a[ln]     = 32'h80;
                drv_b[ln]     = 32'h7F;
            end else begin
                drv_start[ln] = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        drv_start[ln] = 1'b0;
        check("latency", 64'(lat), 64'(w));
        check("done_seen", 64'(mon_done[ln]), 64'd1);
        check("diff", 64'(mon_diff[ln]), full & mask);
        check("borrow", 64'(mon_borrow[ln]), (full >> w) & 64'd1);
        check("ready_in_done", 64'(mon_ready[ln]), 64'd0);
        @(negedge clk);
        check("done_one_cycle", 64'(mon_done[ln]), 64'd0);
        check("ready_back", 64'(mon_ready[ln]), 64'd1);
        check("diff_hold", 64'(mon_diff[ln]), full & mask);
    endtask

    task automatic sweep(input int ln);
        for (int n = 0; n < NOPS; n++) begin
            run_op(ln, $urandom, $urandom, 1'b0);
        end
    endtask

    initial begin
        int cyc;
        int last;
        int cnt;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drv_start[i] = 1'b0;
            drv_a[i]     = '0;
            drv_b[i]     = '0;
        end
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("rst_ready", 64'(mon_ready[i]), 64'd1);
            check("rst_busy", 64'(mon_busy[i]), 64'd0);
            check("rst_done", 64'(mon_done[i]), 64'd0);
            check("rst_diff", 64'(mon_diff[i]), 64'd0);
            check("rst_borrow", 64'(mon_borrow[i]), 64'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_op(1, 32'h35, 32'h12, 1'b0);
        check("d35_12", 64'(mon_diff[1]), 64'h23);
        check("b35_12", 64'(mon_borrow[1]), 64'd0);
        run_op(1, 32'h12, 32'h35, 1'b0);
        check("d12_35", 64'(mon_diff[1]), 64'hDD);
        check("b12_35", 64'(mon_borrow[1]), 64'd1);
        run_op(1, 32'h00, 32'h01, 1'b0);
        check("d00_01", 64'(mon_diff[1]), 64'hFF);
        check("b00_01", 64'(mon_borrow[1]), 64'd1);
        run_op(1, 32'hFF, 32'hFF, 1'b1);
        @(negedge clk);
        check("dFF_FF_idle", 64'(mon_diff[1]), 64'h00);
        check("bFF_FF_idle", 64'(mon_borrow[1]), 64'd0);
        run_op(1, 32'h80, 32'h7F, 1'b0);
        check("d80_7F", 64'(mon_diff[1]), 64'h01);
        check("b80_7F", 64'(mon_borrow[1]), 64'd0);

        // Abort mid-RUN, then restart in the very cycle reset drops.
        drv_start[1] = 1'b1;
        drv_a[1]     = 32'hA0;
        drv_b[1]     = 32'h0F;
        @(posedge clk);
        repeat (4) @(negedge clk);
        drv_start[1] = 1'b0;
        rst = 1'b1;
        #1;
        check("abort_ready", 64'(mon_ready[1]), 64'd1);
        check("abort_busy", 64'(mon_busy[1]), 64'd0);
        check("abort_done", 64'(mon_done[1]), 64'd0);
        check("abort_diff", 64'(mon_diff[1]), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op(1, 32'hA0, 32'h0F, 1'b0);
        check("dA0_0F", 64'(mon_diff[1]), 64'h91);
        check("bA0_0F", 64'(mon_borrow[1]), 64'd0);

        // start held high: three back-to-back operations.
        drv_start[1] = 1'b1;
        drv_a[1]     = 32'h10;
        drv_b[1]     = 32'h03;
        cyc  = 0;
        last = 0;
        cnt  = 0;
        while (cnt < 3 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (mon_busy[1] || mon_done[1]) begin
                check("held_ready_low", 64'(mon_ready[1]), 64'd0);
            end
            if (mon_done[1]) begin
                if (cnt > 0) begin
                    check("held_spacing", 64'(cyc - last), 64'd10);
                end
                check("held_diff", 64'(mon_diff[1]), 64'h0D);
                last = cyc;
                cnt++;
                if (cnt == 3) begin
                    drv_start[1] = 1'b0;
                end
            end
        end
        drv_start[1] = 1'b0;
        check("held_count", 64'(cnt), 64'd3);
        @(negedge clk);

        fork
            sweep(0);
            sweep(1);
            sweep(2);
        join

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
